// File: rtl/alu_result_stage.sv
// alu_result_stage
//   Registered output stage behind the data-merge unit. Buffers the merged
//   result word and its zero flag in a 2-entry FIFO. The valid/ready
//   handshake on the writeback side is decoupled from the merge path: there
//   is no combinational path from out_ready to in_ready and no in->out bypass.
//   Also keeps a sticky zero flag and a wrapping count of delivered results.
//
// Parameters
//   DATA_W        result word width
//   CNT_W         delivered-result counter width
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   in_valid/in_ready/in_data/in_zero       upstream handshake and payload
//   out_valid/out_ready/out_data/out_zero   downstream handshake and head entry
//   sticky_zero, sticky_clr   sticky "a zero result was accepted" flag, sync clear
//   result_count              number of out-side handshakes, wraps silently
//   zero_err                  sticky zero-flag consistency error
//
// Build option
//   ALU_RESULT_ZERO_CHECK_EN  when defined, each pushed in_zero is compared
//                             against (in_data == 0). A mismatch sets zero_err
//                             until reset. When undefined, zero_err is tied low.

module alu_result_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_zero,
    output logic              sticky_zero,
    input  logic              sticky_clr,
    output logic [CNT_W-1:0]  result_count,
    output logic              zero_err
);

    logic [1:0][DATA_W-1:0] mem_data;
    logic [1:0]             mem_zero;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             count;
    logic                   push;
    logic                   pop;

    // in_ready is gated by rst so nothing is offered as accepted while the
    // stage is held in reset; otherwise it depends on registered count only.
    assign in_ready  = ~rst & (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem_data[rd_ptr];
    assign out_zero  = mem_zero[rd_ptr];

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_data     <= '0;
            mem_zero     <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
            sticky_zero  <= 1'b0;
            result_count <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= in_data;
                mem_zero[wr_ptr] <= in_zero;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr       <= ~rd_ptr;
                result_count <= result_count + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            // set has priority over clear
            if (push && in_zero) begin
                sticky_zero <= 1'b1;
            end else if (sticky_clr) begin
                sticky_zero <= 1'b0;
            end
        end
    end

`ifdef ALU_RESULT_ZERO_CHECK_EN
    logic zero_mismatch;

    assign zero_mismatch = in_zero != (in_data == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_err <= 1'b0;
        end else if (push && zero_mismatch) begin
            zero_err <= 1'b1;
        end
    end
`else
    assign zero_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    localparam int DW = 32;
    localparam int CW = 16;
`ifdef ALU_RESULT_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_zero;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_zero;
    logic          sticky_zero;
    logic          sticky_clr;
    logic [CW-1:0] result_count;
    logic          zero_err;

    alu_result_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_zero      (in_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_zero     (out_zero),
        .sticky_zero  (sticky_zero),
        .sticky_clr   (sticky_clr),
        .result_count (result_count),
        .zero_err     (zero_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: a queue of pending results plus the sticky state
    typedef struct {
        logic [DW-1:0] d;
        logic          z;
    } ent_t;
    ent_t          q[$];
    logic [CW-1:0] m_rc;
    logic          m_sticky;
    logic          m_err;

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          z;
        logic          ordy;
        logic          clr;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic          e_oz;
        logic          e_ir;
        logic          e_sticky;
        logic [CW-1:0] e_rc;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rc     = '0;
        m_sticky = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic model_check();
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("sticky_zero", 32'(sticky_zero), 32'(m_sticky));
        chk("result_count", 32'(result_count), 32'(m_rc));
        chk("zero_err", 32'(zero_err), 32'(m_err));
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_zero", 32'(out_zero), 32'(q[0].z));
        end
    endtask

    // one clock: predict handshakes from the current inputs, advance, update model
    task automatic step(input bit mcheck);
        bit   push;
        bit   pop;
        ent_t e;
        push = in_valid && (q.size() < 2);
        pop  = out_ready && (q.size() > 0);
        @(posedge clk);
        #1;
        if (pop) begin
            e = q.pop_front();
            m_rc = m_rc + 1'b1;
        end
        if (push) begin
            e.d = in_data;
            e.z = in_zero;
            q.push_back(e);
            if (ZC && (in_zero != (in_data == 0))) m_err = 1'b1;
        end
        if (push && in_zero) m_sticky = 1'b1;
        else if (sticky_clr) m_sticky = 1'b0;
        if (mcheck) model_check();
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic z,
                         input logic ordy, input logic clr);
        in_valid   = iv;
        in_data    = d;
        in_zero    = z;
        out_ready  = ordy;
        sticky_clr = clr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_in_ready", 32'(in_ready), 32'd0);
        chk("rst_hold_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_count", 32'(result_count), 32'd0);
        chk("post_rst_sticky", 32'(sticky_zero), 32'd0);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_zero_err", 32'(zero_err), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          z;

        //            iv  data          z     ordy  clr   ov    od            oz    ir    stk   rc
        vecs[0] = '{1'b1, 32'hABCD1234, 1'b0, 1'b1, 1'b0, 1'b1, 32'hABCD1234, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[1] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 16'd1};
        vecs[2] = '{1'b1, 32'h11110000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11110000, 1'b0, 1'b1, 1'b0, 16'd1};
        vecs[3] = '{1'b1, 32'h22220001, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11110000, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[4] = '{1'b1, 32'h33330002, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11110000, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[5] = '{1'b0, 32'h33330002, 1'b0, 1'b1, 1'b0, 1'b1, 32'h22220001, 1'b0, 1'b1, 1'b0, 16'd2};
        vecs[6] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 16'd3};
        vecs[7] = '{1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b1, 16'd3};
        vecs[8] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 16'd4};

        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_check();

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].z, vecs[i].ordy, vecs[i].clr);
            step(1'b1);
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            chk($sformatf("vec%0d_sticky", i), 32'(sticky_zero), 32'(vecs[i].e_sticky));
            chk($sformatf("vec%0d_count", i), 32'(result_count), 32'(vecs[i].e_rc));
            if (vecs[i].e_ov) begin
                chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
                chk($sformatf("vec%0d_out_zero", i), 32'(out_zero), 32'(vecs[i].e_oz));
            end
        end

        // reset with two entries buffered
        drive(1'b1, 32'h5A5A0001, 1'b0, 1'b0, 1'b0);
        step(1'b1);
        drive(1'b1, 32'h5A5A0002, 1'b0, 1'b0, 1'b0);
        step(1'b1);
        chk("full_before_rst", 32'(in_ready), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        do_reset();

        // steady stream of words 0..9
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, DW'(i), (i == 0), 1'b1, 1'b0);
            step(1'b1);
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b1);
        chk("stream_count", 32'(result_count), 32'd10);

        // randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            d = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
            z = (d == 0);
            if ($urandom_range(0, 7) == 0) z = ~z;
            drive(1'($urandom_range(0, 1)), d, z, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 5) == 0));
            step(1'b1);
        end

        // counter wrap: stream until the count reaches all-ones, then one more pop
        for (int i = 0; i < 70000 && m_rc != {CW{1'b1}}; i++) begin
            d = DW'($urandom) | 32'h1;
            drive(1'b1, d, 1'b0, 1'b1, 1'b0);
            step(1'b0);
        end
        model_check();
        chk("count_pre_wrap", 32'(result_count), 32'h0000FFFF);
        drive(1'b1, 32'h7, 1'b0, 1'b1, 1'b0);
        step(1'b1);
        chk("count_wrap", 32'(result_count), 32'd0);

        // zero flag consistency check
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        do_reset();
        drive(1'b1, 32'h00010000, 1'b1, 1'b0, 1'b0);
        step(1'b1);
        chk("zero_err_set", 32'(zero_err), 32'(ZC));
        chk("zero_err_out_zero", 32'(out_zero), 32'd1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1);
        chk("zero_err_after_clr", 32'(zero_err), 32'(ZC));
        chk("sticky_after_clr", 32'(sticky_zero), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
